// File: rtl/instruction_queue.sv
// Instruction queue between fetch and decode: circular buffer of {inst, pc, is_c}.
// Latency: a pushed entry is visible at the head one cycle after the push (no bypass).
// Backpressure: registered iq_full warns fetch early; a push into a full queue with no pop is dropped and sets overflow.
//
// Ports:
//   clk, rst_n       - clock and asynchronous active-low reset
//   flush            - synchronous flush from fetch; empties the queue, wins over push/pop
//   instruction      - fetched word; zero means nothing to push this cycle
//   in_pc            - PC of the word on instruction
//   deq_ready        - decoder takes the head entry this cycle
//   out_valid        - head entry is valid
//   out_inst/out_pc  - head instruction and PC (show-ahead, combinational from head)
//   out_is_c         - head instruction is a 16-bit compressed encoding
//   iq_full          - registered back-pressure, asserted FULL_MARGIN slots before truly full
//   count            - current occupancy, 0..DEPTH
//   overflow         - sticky drop indicator, cleared only by reset

module instruction_queue #(
    parameter int DEPTH       = 8,
    parameter int FULL_MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [31:0]              instruction,
    input  logic [31:0]              in_pc,
    input  logic                     deq_ready,
    output logic                     out_valid,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic                     out_is_c,
    output logic                     iq_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH - FULL_MARGIN);
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_c;
    } entry_t;

    // Entry storage carries no reset; validity is tracked purely by count.
    entry_t          mem [DEPTH];

    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            drop;
    logic [AW:0]     count_next;
    entry_t          head_entry;

    // ------------------------------------------------------------------
    // Push / pop qualification
    // ------------------------------------------------------------------
    always_comb begin
        push_req = (instruction != 32'd0) && !flush;
        pop      = out_valid && deq_ready && !flush;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        push     = push_req && ((count < DEPTH_CNT) || pop);
        drop     = push_req && !push;
    end

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CNT_ONE;
                2'b01:   count_next = count - CNT_ONE;
                default: count_next = count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            iq_full  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count <= count_next;
            if (flush) begin
                head    <= '0;
                tail    <= '0;
                iq_full <= 1'b0;
            end else begin
                if (push) begin
                    tail <= tail + PTR_ONE;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
                // Registered so fetch sees the warning from a flop, computed
                // from next-state occupancy to stay cycle-accurate.
                iq_full <= (count_next >= FULL_LVL);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{inst: instruction,
                           pc:   in_pc,
                           is_c: (instruction[1:0] != 2'b11)};
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead head outputs
    // ------------------------------------------------------------------
    always_comb begin
        head_entry = mem[head];
        out_valid  = (count != '0);
        out_inst   = out_valid ? head_entry.inst : 32'd0;
        out_pc     = head_entry.pc;
        out_is_c   = out_valid && head_entry.is_c;
    end

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= DEPTH_CNT);

    // Pointer distance must always agree with occupancy (modulo DEPTH).
    a_ptr_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (tail - head) == count[AW-1:0]);

endmodule

// File: tb/tb_instruction_queue.sv
module tb_instruction_queue;

    localparam int DEPTH       = 8;
    localparam int FULL_MARGIN = 1;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] instruction;
    logic [31:0] in_pc;
    logic        deq_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_is_c;
    logic        iq_full;
    logic [3:0]  count;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain FIFO of {inst, pc}, sticky overflow, full flag.
    logic [63:0] mq[$];
    logic        m_ovf;
    logic        m_full;

    instruction_queue #(.DEPTH(DEPTH), .FULL_MARGIN(FULL_MARGIN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .instruction (instruction),
        .in_pc       (in_pc),
        .deq_ready   (deq_ready),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_is_c    (out_is_c),
        .iq_full     (iq_full),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model across the edge, and
    // leave the bench 1 time unit after the edge for sampling.
    task automatic step(input logic [31:0] i, input logic [31:0] p,
                        input logic dr, input logic fl);
        instruction = i;
        in_pc       = p;
        deq_ready   = dr;
        flush       = fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_full = 1'b0;
        end else begin
            if (mq.size() != 0 && dr) void'(mq.pop_front());
            if (i != 32'd0) begin
                if (mq.size() < DEPTH) mq.push_back({i, p});
                else m_ovf = 1'b1;
            end
            m_full = (mq.size() >= DEPTH - FULL_MARGIN);
        end
        #1;
        instruction = 32'd0;
        in_pc       = 32'd0;
        deq_ready   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_full = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (count !== 4'd0)   begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (out_inst !== 32'd0) begin n_bad++; $display("FAIL reset_inst got=%h exp=0", out_inst); end
        n_cmp++; if (iq_full !== 1'b0)  begin n_bad++; $display("FAIL reset_full got=%0b exp=0", iq_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_order();
        step(32'h0050_0093, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid1 got=%0b exp=1", out_valid); end
        n_cmp++; if (out_inst !== 32'h0050_0093) begin n_bad++; $display("FAIL basic_inst1 got=%h exp=00500093", out_inst); end
        n_cmp++; if (out_is_c !== 1'b0) begin n_bad++; $display("FAIL basic_isc1 got=%0b exp=0", out_is_c); end
        n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL basic_pc1 got=%h exp=0", out_pc); end
        step(32'h0000_4501, 32'h4, 1'b1, 1'b0);
        n_cmp++; if (out_inst !== 32'h0000_4501) begin n_bad++; $display("FAIL basic_inst2 got=%h exp=00004501", out_inst); end
        n_cmp++; if (out_is_c !== 1'b1) begin n_bad++; $display("FAIL basic_isc2 got=%0b exp=1", out_is_c); end
        n_cmp++; if (out_pc !== 32'h4) begin n_bad++; $display("FAIL basic_pc2 got=%h exp=4", out_pc); end
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL basic_count2 got=%0d exp=1", count); end
        step(32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL basic_drain got=%0d exp=0", count); end
        n_cmp++; if (out_inst !== 32'd0) begin n_bad++; $display("FAIL basic_empty_inst got=%h exp=0", out_inst); end
    endtask

    task automatic test_fill_full();
        for (int k = 0; k < DEPTH; k++) begin
            step(32'h1000_0003 + 32'(k << 8), 32'h100 + 32'(k * 4), 1'b0, 1'b0);
            n_cmp++;
            if (iq_full !== (k >= DEPTH - 2)) begin
                n_bad++; $display("FAIL fill_full push=%0d got=%0b exp=%0b", k + 1, iq_full, (k >= DEPTH - 2));
            end
        end
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_count got=%0d exp=8", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_ovf_pre got=%0b exp=0", overflow); end
        step(32'hDEAD_BEEF, 32'h200, 1'b0, 1'b0);
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL drop_count got=%0d exp=8", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL drop_ovf got=%0b exp=1", overflow); end
        n_cmp++; if (out_inst !== 32'h1000_0003) begin n_bad++; $display("FAIL drop_head got=%h exp=10000003", out_inst); end
        n_cmp++; if (out_pc !== 32'h100) begin n_bad++; $display("FAIL drop_head_pc got=%h exp=100", out_pc); end
    endtask

    task automatic test_push_pop_full();
        logic [63:0] e;
        step(32'h0000_1234, 32'h300, 1'b1, 1'b0);
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL ppf_count got=%0d exp=8", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ppf_ovf got=%0b exp=1", overflow); end
        n_cmp++; if (out_inst !== 32'h1000_0103) begin n_bad++; $display("FAIL ppf_head got=%h exp=10000103", out_inst); end
        // Drain across the wrap; order must match the model FIFO.
        for (int k = 0; k < DEPTH; k++) begin
            e = mq[0];
            n_cmp++;
            if (out_inst !== e[63:32] || out_pc !== e[31:0]) begin
                n_bad++; $display("FAIL ppf_order idx=%0d got=%h/%h exp=%h/%h", k, out_inst, out_pc, e[63:32], e[31:0]);
            end
            step(32'h0, 32'h0, 1'b1, 1'b0);
        end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL ppf_empty got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) step(32'h2000_0013 + 32'(k), 32'h400 + 32'(k * 4), 1'b0, 1'b0);
        n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL flush_pre got=%0d exp=5", count); end
        step(32'hABCD_0001, 32'h500, 1'b1, 1'b1);
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (iq_full !== 1'b0) begin n_bad++; $display("FAIL flush_full got=%0b exp=0", iq_full); end
        step(32'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL flush_nostore got=%0d exp=0", count); end
        // Flush from full must also drop iq_full.
        for (int k = 0; k < DEPTH; k++) step(32'h3000_0001 + 32'(k), 32'(k), 1'b0, 1'b0);
        step(32'h0, 32'h0, 1'b0, 1'b1);
        n_cmp++; if (iq_full !== 1'b0 || count !== 4'd0) begin n_bad++; $display("FAIL flush_from_full got=%0b/%0d exp=0/0", iq_full, count); end
    endtask

    task automatic test_zero_filter();
        for (int k = 0; k < 3; k++) step(32'h4000_0000 + 32'(k), 32'h600 + 32'(k * 4), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(32'h0, 32'h700, 1'b0, 1'b0);
            n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL zero_count cyc=%0d got=%0d exp=3", k, count); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL arst_count got=%0d exp=0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL arst_ovf got=%0b exp=0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h0000_0001, 32'h800, 1'b0, 1'b0);
        n_cmp++; if (count !== 4'd1 || out_inst !== 32'h1) begin n_bad++; $display("FAIL arst_first_push got=%0d/%h exp=1/00000001", count, out_inst); end
    endtask

    task automatic test_random();
        logic [31:0] i;
        logic [31:0] p;
        logic [63:0] e;
        logic        exp_valid;
        logic [31:0] exp_inst;
        for (int c = 0; c < 600; c++) begin
            i = ($urandom_range(0, 99) < 25) ? 32'd0 : $urandom;
            p = $urandom;
            step(i, p, ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
            exp_valid = (mq.size() != 0);
            e         = exp_valid ? mq[0] : 64'd0;
            exp_inst  = e[63:32];
            n_cmp++; if (count !== 4'(mq.size())) begin n_bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count, mq.size()); end
            n_cmp++; if (out_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", c, out_valid, exp_valid); end
            n_cmp++; if (out_inst !== exp_inst) begin n_bad++; $display("FAIL rnd_inst cyc=%0d got=%h exp=%h", c, out_inst, exp_inst); end
            if (exp_valid) begin
                n_cmp++; if (out_pc !== e[31:0]) begin n_bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", c, out_pc, e[31:0]); end
                n_cmp++; if (out_is_c !== (exp_inst[1:0] != 2'b11)) begin n_bad++; $display("FAIL rnd_isc cyc=%0d got=%0b exp=%0b", c, out_is_c, (exp_inst[1:0] != 2'b11)); end
            end
            n_cmp++; if (iq_full !== m_full) begin n_bad++; $display("FAIL rnd_full cyc=%0d got=%0b exp=%0b", c, iq_full, m_full); end
            n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", c, overflow, m_ovf); end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        instruction = 32'd0;
        in_pc       = 32'd0;
        deq_ready   = 1'b0;
        test_reset();
        test_basic_order();
        test_fill_full();
        test_push_pop_full();
        test_flush();
        test_zero_filter();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
